// File: rtl/debug_uart_rx_pkg.sv
// Shared types and register layout for the debug UART receiver.
package debug_uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int unsigned ST_AVAIL     = 31;
    localparam int unsigned ST_FULL      = 30;
    localparam int unsigned ST_OVERRUN   = 29;
    localparam int unsigned ST_FRAME_ERR = 28;
    localparam int unsigned ST_COUNT_LSB = 24;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: rx synchroniser, bit-timing FSM and shift register.
// Emits a byte with a one-cycle push strobe, or a frame-error strobe.
module uart_rx_core
    import debug_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       push_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);

    logic             sync1_q, sync2_q, rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             falling;

    assign falling = rx_prev_q & ~sync2_q;
    assign byte_o  = shift_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_o      = 1'b0;
        frame_err_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (falling) begin
                    cnt_d   = HALF_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_BIT;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    push_o      = sync2_q;
                    frame_err_o = ~sync2_q;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/debug_uart_rx.sv
// Memory-mapped debug UART receiver: receive FIFO plus DATA/STATUS registers.
// Optional receive interrupt built when DEBUG_UART_RX_IRQ_EN is defined.
module debug_uart_rx
    import debug_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hf00000e0
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        rx,
    input  logic [31:0] address,
    input  logic        data_access,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       core_byte;
    logic             core_push, core_ferr;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [31:0]      data_read_q, data_read_d;

    logic             rd, wr, sel_data, sel_status;
    logic             empty, full, pop, push_ok, ovf;
    logic [6:0]       count_ext;
    logic [3:0]       count_disp;
    logic [31:0]      status_word;
    logic             unused_write;

    uart_rx_core #(
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk_i       (clock_in),
        .rst_i       (reset),
        .rx_i        (rx),
        .byte_o      (core_byte),
        .push_o      (core_push),
        .frame_err_o (core_ferr)
    );

    assign rd         = data_access & ~(|data_we);
    assign wr         = data_access & (|data_we);
    assign sel_data   = (address == BASE_ADDR + DATA_OFS);
    assign sel_status = (address == BASE_ADDR + STATUS_OFS);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = rd & sel_data & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = core_push & (~full | pop);
    assign ovf        = core_push & full & ~pop;
    assign count_ext  = 7'(count_q);
    assign count_disp = (count_ext > 7'd15) ? 4'hF : count_ext[3:0];
    assign unused_write = ^{data_write[31:30], data_write[27:0]};
    assign data_read  = data_read_q;

    always_comb begin
        status_word                          = '0;
        status_word[ST_AVAIL]                = ~empty;
        status_word[ST_FULL]                 = full;
        status_word[ST_OVERRUN]              = overrun_q;
        status_word[ST_FRAME_ERR]            = frame_err_q;
        status_word[ST_COUNT_LSB +: 4]       = count_disp;
    end

    always_comb begin
        count_d     = count_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        data_read_d = data_read_q;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clears are applied first so an error arriving in the same cycle survives.
        if (sel_status && (rd || (wr && data_write[29]))) overrun_d = 1'b0;
        if (sel_status && (rd || (wr && data_write[28]))) frame_err_d = 1'b0;
        if (ovf)       overrun_d   = 1'b1;
        if (core_ferr) frame_err_d = 1'b1;

        if (rd) begin
            if (sel_data)        data_read_d = pop ? {mem_q[rd_ptr_q], 24'h0} : '0;
            else if (sel_status) data_read_d = status_word;
            else                 data_read_d = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= core_byte;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_read_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            data_read_q <= data_read_d;
        end
    end

`ifdef DEBUG_UART_RX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock_in) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (count_q != '0) | overrun_q | frame_err_q;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
